// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO pointer/flag controller.
package fifo_pkg;

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_empty;
        logic almost_full;
        logic overflow;
        logic underflow;
    } fifo_status_t;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/fifo_ctrl_ext_if.sv
// Handshake and status bundle between a FIFO user (master) and the controller (slave).
interface fifo_ctrl_ext_if #(
    parameter int ADDR_WIDTH = 4
);
    logic                  i_rd;
    logic                  i_wr;
    logic                  i_flush;
    logic                  i_err_clr;
    logic [ADDR_WIDTH-1:0] o_w_addr;
    logic [ADDR_WIDTH-1:0] o_r_addr;
    logic                  o_wr_ok;
    logic                  o_rd_ok;
    logic [ADDR_WIDTH:0]   o_count;
    logic                  o_empty;
    logic                  o_full;
    logic                  o_almost_empty;
    logic                  o_almost_full;
    logic                  o_overflow;
    logic                  o_underflow;

    modport master (
        output i_rd, i_wr, i_flush, i_err_clr,
        input  o_w_addr, o_r_addr, o_wr_ok, o_rd_ok, o_count,
        input  o_empty, o_full, o_almost_empty, o_almost_full,
        input  o_overflow, o_underflow
    );

    modport slave (
        input  i_rd, i_wr, i_flush, i_err_clr,
        output o_w_addr, o_r_addr, o_wr_ok, o_rd_ok, o_count,
        output o_empty, o_full, o_almost_empty, o_almost_full,
        output o_overflow, o_underflow
    );

endinterface

// File: rtl/fifo_ptr.sv
// Wrapping FIFO address pointer: advances on i_inc, returns to 0 on i_clr or reset.
module fifo_ptr #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_inc,
    input  logic                  i_clr,
    output logic [ADDR_WIDTH-1:0] o_ptr
);

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] r_ptr;

    // Wrap DEPTH-1 -> 0 falls out of the power-of-two width.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (i_clr) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= r_ptr + PTR_ONE;
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/fifo_ctrl_ext.sv
// FIFO pointer/flag controller: occupancy count, threshold flags, accept strobes,
// sticky overflow/underflow and synchronous flush for a 2**ADDR_WIDTH register file.
module fifo_ctrl_ext
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int AF_THRESH  = 12,
    parameter int AE_THRESH  = 2
) (
    input  logic         clk,
    input  logic         reset,
    fifo_ctrl_ext_if.slave bus
);

    localparam int              DEPTH   = fifo_depth(ADDR_WIDTH);
    localparam int              CW      = ADDR_WIDTH + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]   AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0]   AE_C    = CW'(AE_THRESH);
    localparam logic [CW-1:0]   ONE_C   = CW'(1);

    localparam fifo_status_t ST_RESET = '{
        empty:        1'b1,
        full:         1'b0,
        almost_empty: 1'b1,
        almost_full:  1'b0,
        overflow:     1'b0,
        underflow:    1'b0
    };

    logic                  w_rd_ok;
    logic                  w_wr_ok;
    logic                  w_ovf_evt;
    logic                  w_unf_evt;
    logic [CW-1:0]         r_count;
    logic [CW-1:0]         w_count_next;
    fifo_status_t          r_status;
    fifo_status_t          w_status_next;
    logic [ADDR_WIDTH-1:0] w_w_addr;
    logic [ADDR_WIDTH-1:0] w_r_addr;

    // A read frees a slot in the same cycle, so a full FIFO still takes rd+wr together.
    assign w_rd_ok   = bus.i_rd & ~r_status.empty & ~bus.i_flush;
    assign w_wr_ok   = bus.i_wr & ~bus.i_flush & (~r_status.full | w_rd_ok);
    assign w_ovf_evt = bus.i_wr & r_status.full & ~w_rd_ok & ~bus.i_flush;
    assign w_unf_evt = bus.i_rd & r_status.empty & ~bus.i_flush;

    always_comb begin
        w_count_next = r_count;
        if (bus.i_flush) begin
            w_count_next = '0;
        end else if (w_wr_ok && !w_rd_ok) begin
            w_count_next = r_count + ONE_C;
        end else if (w_rd_ok && !w_wr_ok) begin
            w_count_next = r_count - ONE_C;
        end
    end

    // A fresh error outranks err_clr in the same cycle; flush leaves errors alone.
    always_comb begin
        w_status_next              = r_status;
        w_status_next.empty        = (w_count_next == '0);
        w_status_next.full         = (w_count_next == DEPTH_C);
        w_status_next.almost_empty = (w_count_next <= AE_C);
        w_status_next.almost_full  = (w_count_next >= AF_C);
        w_status_next.overflow     = w_ovf_evt | (r_status.overflow & ~bus.i_err_clr);
        w_status_next.underflow    = w_unf_evt | (r_status.underflow & ~bus.i_err_clr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count  <= '0;
            r_status <= ST_RESET;
        end else begin
            r_count  <= w_count_next;
            r_status <= w_status_next;
        end
    end

    fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wptr (
        .clk   (clk),
        .reset (reset),
        .i_inc (w_wr_ok),
        .i_clr (bus.i_flush),
        .o_ptr (w_w_addr)
    );

    fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rptr (
        .clk   (clk),
        .reset (reset),
        .i_inc (w_rd_ok),
        .i_clr (bus.i_flush),
        .o_ptr (w_r_addr)
    );

    assign bus.o_w_addr       = w_w_addr;
    assign bus.o_r_addr       = w_r_addr;
    assign bus.o_wr_ok        = w_wr_ok;
    assign bus.o_rd_ok        = w_rd_ok;
    assign bus.o_count        = r_count;
    assign bus.o_empty        = r_status.empty;
    assign bus.o_full         = r_status.full;
    assign bus.o_almost_empty = r_status.almost_empty;
    assign bus.o_almost_full  = r_status.almost_full;
    assign bus.o_overflow     = r_status.overflow;
    assign bus.o_underflow    = r_status.underflow;

endmodule

// File: tb/tb_fifo_ctrl_ext.sv
// Scoreboard bench for fifo_ctrl_ext at DEPTH=4: a queue-of-addresses reference model
// predicts each cycle's outputs; a negedge monitor pops and compares.
module tb_fifo_ctrl_ext;

    localparam int AW = 2;
    localparam int D  = 4;
    localparam int AF = 3;
    localparam int AE = 1;

    logic clk;
    logic reset;

    fifo_ctrl_ext_if #(.ADDR_WIDTH(AW)) bus ();

    fifo_ctrl_ext #(
        .ADDR_WIDTH (AW),
        .AF_THRESH  (AF),
        .AE_THRESH  (AE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit wr_ok;
        bit rd_ok;
        int w_addr;
        int r_addr;
        int count;
        bit empty;
        bit full;
        bit ae;
        bit af;
        bit ovf;
        bit unf;
        int front;
    } exp_t;

    exp_t sb[$];

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the FIFO is a queue of the addresses its entries were written to.
    int q_addr[$];
    int wp = 0;
    int rp = 0;
    bit m_ovf = 1'b0;
    bit m_unf = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_addr.delete();
        wp    = 0;
        rp    = 0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic drive(input bit rd, input bit wr, input bit fl, input bit ec);
        exp_t e;
        int   cnt;
        bit   ra, wa, oe, ue;
        bus.i_rd      = rd;
        bus.i_wr      = wr;
        bus.i_flush   = fl;
        bus.i_err_clr = ec;
        cnt = q_addr.size();
        ra  = rd && !fl && (cnt > 0);
        wa  = wr && !fl && ((cnt < D) || ra);
        oe  = wr && !fl && (cnt == D) && !ra;
        ue  = rd && !fl && (cnt == 0);
        e.wr_ok  = wa;
        e.rd_ok  = ra;
        e.w_addr = wp;
        e.r_addr = rp;
        e.count  = cnt;
        e.empty  = (cnt == 0);
        e.full   = (cnt == D);
        e.ae     = (cnt <= AE);
        e.af     = (cnt >= AF);
        e.ovf    = m_ovf;
        e.unf    = m_unf;
        e.front  = (cnt > 0) ? q_addr[0] : -1;
        sb.push_back(e);
        if (fl) begin
            q_addr.delete();
            wp = 0;
            rp = 0;
        end else begin
            if (ra) begin
                void'(q_addr.pop_front());
                rp = (rp + 1) % D;
            end
            if (wa) begin
                q_addr.push_back(wp);
                wp = (wp + 1) % D;
            end
        end
        m_ovf = oe || (m_ovf && !ec);
        m_unf = ue || (m_unf && !ec);
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("wr_ok",        int'(bus.o_wr_ok),        int'(e.wr_ok));
                chk("rd_ok",        int'(bus.o_rd_ok),        int'(e.rd_ok));
                chk("w_addr",       int'(bus.o_w_addr),       e.w_addr);
                chk("r_addr",       int'(bus.o_r_addr),       e.r_addr);
                chk("count",        int'(bus.o_count),        e.count);
                chk("empty",        int'(bus.o_empty),        int'(e.empty));
                chk("full",         int'(bus.o_full),         int'(e.full));
                chk("almost_empty", int'(bus.o_almost_empty), int'(e.ae));
                chk("almost_full",  int'(bus.o_almost_full),  int'(e.af));
                chk("overflow",     int'(bus.o_overflow),     int'(e.ovf));
                chk("underflow",    int'(bus.o_underflow),    int'(e.unf));
                if (e.front >= 0)
                    chk("head_addr", int'(bus.o_r_addr), e.front);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        bus.i_rd      = 1'b0;
        bus.i_wr      = 1'b0;
        bus.i_flush   = 1'b0;
        bus.i_err_clr = 1'b0;
        reset         = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        drive(0, 0, 0, 0);
        drive(1, 0, 0, 0);
        repeat (3) drive(0, 1, 0, 0);

        // Asynchronous reset mid-stream: outputs must clear without a clock edge.
        bus.i_rd = 1'b0; bus.i_wr = 1'b0; bus.i_flush = 1'b0; bus.i_err_clr = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("rst_w_addr",    int'(bus.o_w_addr),       0);
        chk("rst_r_addr",    int'(bus.o_r_addr),       0);
        chk("rst_count",     int'(bus.o_count),        0);
        chk("rst_empty",     int'(bus.o_empty),        1);
        chk("rst_full",      int'(bus.o_full),         0);
        chk("rst_ae",        int'(bus.o_almost_empty), 1);
        chk("rst_af",        int'(bus.o_almost_full),  0);
        chk("rst_overflow",  int'(bus.o_overflow),     0);
        chk("rst_underflow", int'(bus.o_underflow),    0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;

        drive(0, 0, 0, 0);
        repeat (4) drive(0, 1, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 1, 0, 0);
        repeat (2) drive(0, 0, 0, 0);
        repeat (2) drive(1, 1, 0, 0);
        drive(0, 1, 0, 1);
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 0);
        repeat (4) drive(1, 0, 0, 0);
        drive(1, 1, 0, 0);
        drive(0, 0, 0, 0);
        repeat (2) drive(0, 1, 0, 0);
        drive(0, 1, 1, 0);
        drive(0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            drive(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 11) == 0));
        end
        drive(0, 0, 0, 0);

        @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
